dataflow_deadlock_monitor: RTL and testbench
============================================

# dataflow_deadlock_monitor

Parametrised, synthesizable deadlock and stall monitor for an HLS dataflow region of `N_PROC` processes. It replaces the fixed two-process simulation-only detector. Each cycle it takes per-process blocking indications and `ap_done`/`ap_continue`. It reports a deadlock when every unfinished process has been blocked for `threshold` consecutive cycles. On detection it latches the origin process and a snapshot of the blocked vector for debug readout, and holds them until cleared.

## Interface
- `N_PROC`, default 2: number of monitored dataflow processes, 1–32.
- `CNT_W`, default 16: width of the stall counter and threshold.
- `STICKY`, default 1: 1 = detection holds until `clear`; 0 = detection drops when the candidate condition drops.

Ports:
- `dl_clock` in 1: the single clock.
- `dl_reset` in 1: reset, synchronous, active-low.
- `proc_blk` in N_PROC: per process, OR of FIFO, PIPO, start-FIFO, TLF and input-sync blocking.
- `proc_done` in N_PROC: per-process `ap_done`.
- `proc_continue` in N_PROC: per-process `ap_continue`.
- `all_finish` in 1: the region has completed; suppresses detection.
- `threshold` in CNT_W: number of consecutive candidate cycles needed to report; a value of 0 is treated as 1.
- `clear` in 1: single-cycle pulse that clears the detection and the counter.
- `dl_detect` out 1: deadlock reported.
- `dl_origin` out N_PROC: one-hot origin process, latched at detection.
- `dl_snapshot` out N_PROC: stuck vector, latched at detection.
- `stall_cnt` out CNT_W: current consecutive-candidate count, saturating.
- `done_reg` out N_PROC: registered `proc_done & ~proc_continue`.

## Operation
- `done_reg[i] <= proc_done[i] & ~proc_continue[i]`, updated every cycle.
- Output-sync blocking: `osync[i] = done_reg[i] & proc_done[i] & ~&proc_done`.
- Stuck vector: `stuck[i] = proc_blk[i] | osync[i]`.
- A process is finished when `done_reg[i] & ~osync[i]`.
- `candidate = ~all_finish & |stuck & ((stuck | finished) == all-ones)`.
- FSM states:
  - IDLE: counter is 0. Moves to COUNT on `candidate`.
  - COUNT: counter increments each cycle `candidate` holds. Returns to IDLE, with counter 0, when `candidate` drops. Moves to DETECTED at the edge where `candidate & (stall_cnt + 1 >= max(threshold, 1))`.
  - DETECTED: `dl_detect = 1`. `dl_origin` and `dl_snapshot` are frozen.
    - With `STICKY = 1`: leaves only on `clear`, going to IDLE.
    - With `STICKY = 0`: also returns to IDLE when `candidate` drops.
- Origin is the lowest-index set bit of `stuck` in the detection cycle. If `stuck` has no set bit, origin is bit 0; this cannot occur because `candidate` requires `|stuck`.
- `stall_cnt` saturates at all-ones and continues counting in DETECTED while `candidate` holds.
- Priority, highest first: reset, `clear`, `all_finish`, `candidate` logic.
  - `clear` in any state forces IDLE and counter 0. A candidate present in the same cycle starts counting the next cycle.
  - `all_finish` forces IDLE from IDLE or COUNT. A latched DETECTED survives `all_finish` when `STICKY = 1`.
- `threshold` may change at any time. The comparison uses the current value, so lowering it below `stall_cnt` detects at the next candidate edge.

## Timing
- Reset values: `dl_detect = 0`, `dl_origin = 0`, `dl_snapshot = 0`, `stall_cnt = 0`, `done_reg = 0`, state IDLE.
- Reset asserted mid-detection clears everything at the next edge.
- All outputs are registered; there is no combinational path from input to output.
- Latency: with `candidate` true for k consecutive sampled edges, `dl_detect` rises after edge k = max(threshold, 1). With `threshold = 1`, the first candidate edge sets `dl_detect`.
- `osync` uses `done_reg`, so an output-sync stall contributes one cycle after `ap_done` first rises without `ap_continue`.
- `clear` takes effect at its own edge: `dl_detect` is 0 in the following cycle.

## Structure
- Shared package `dl_monitor_pkg`:
  - state enum `dl_state_e` (IDLE, COUNT, DETECTED);
  - function `lowest_onehot(vec)`;
  - constant `DL_MAX_PROC = 32`.
- One sub-module, `dl_proc_status`, instantiated once per process. It registers `done_reg` and produces `stuck[i]` and `finished[i]`. The top level holds the FSM, counter and latches.

## Test plan
- N_PROC=2, threshold=4; `proc_blk=2'b10`, `done_reg[0]` finished, held for 4 cycles → `dl_detect` rises after edge 4, `dl_origin=2'b10`, `dl_snapshot=2'b10`.
- N_PROC=4, threshold=8; all blocked for 7 cycles, then `proc_blk[2]` drops for 1 cycle, then all blocked again → counter returns to 0, and detection occurs 8 cycles after the restart.
- STICKY=1, in DETECTED; `all_finish=1`, then inputs idle → `dl_detect` stays 1. `clear` pulse → `dl_detect=0` next cycle, `stall_cnt=0`.
- STICKY=0, N_PROC=3, threshold=2; detect, then `proc_blk` goes to 0 → `dl_detect` drops after one edge.
- Output-sync case, N_PROC=2: `proc_done=2'b01`, `proc_continue=0` held → `stuck[0]` sets one cycle later; with `proc_blk[1]=1`, detection after `threshold` cycles with `dl_origin=2'b01`.
- `clear` and `candidate` asserted in the same cycle, and `dl_reset=0` asserted in COUNT → state IDLE and `stall_cnt=0` the next cycle; with `candidate` still held, counting restarts at 1 the cycle after.

Source files
------------

// File: rtl/dl_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dl_monitor_pkg
// Purpose  : Shared types, constants and helpers for the dataflow deadlock
//            monitor (state encoding, process-count limit, one-hot isolate).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
package dl_monitor_pkg;

    // Upper bound on monitored processes; vectors are padded to this width
    // whenever a width-independent helper is used.
    localparam int DL_MAX_PROC = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        DETECTED = 2'd2
    } dl_state_e;

    // Isolate the lowest set bit. An all-zero input maps to bit 0 so the
    // result is always a valid one-hot value.
    function automatic logic [DL_MAX_PROC-1:0] lowest_onehot(
        input logic [DL_MAX_PROC-1:0] vec
    );
        logic [DL_MAX_PROC-1:0] w_iso;
        w_iso = vec & ((~vec) + {{(DL_MAX_PROC-1){1'b0}}, 1'b1});
        if (vec == '0) begin
            w_iso = {{(DL_MAX_PROC-1){1'b0}}, 1'b1};
        end
        return w_iso;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_proc_status.sv
`default_nettype none
// ============================================================================
// Module   : dl_proc_status
// Purpose  : Per-process status slice. Registers ap_done-without-continue and
//            classifies the process as stuck (blocked or output-sync stalled)
//            or finished for the deadlock candidate evaluation.
// Ports    : dl_clock, dl_reset (sync, active-low)
//            proc_blk, proc_done, proc_continue : this process' indications
//            all_done  : AND of every process' ap_done
//            done_reg  : registered proc_done & ~proc_continue
//            stuck     : blocked on a channel or waiting at output sync
//            finished  : done and not held back by output sync
// Revision : 1.0 - initial release
// ============================================================================
module dl_proc_status
    import dl_monitor_pkg::*;
(
    input  logic dl_clock,
    input  logic dl_reset,
    input  logic proc_blk,
    input  logic proc_done,
    input  logic proc_continue,
    input  logic all_done,
    output logic done_reg,
    output logic stuck,
    output logic finished
);

    logic r_done_reg;
    logic w_osync;

    always_ff @(posedge dl_clock) begin
        if (!dl_reset) begin
            r_done_reg <= 1'b0;
        end else begin
            r_done_reg <= proc_done & ~proc_continue;
        end
    end

    // A process that has signalled done but is not yet continued is waiting
    // for its siblings, unless every process is done at the same time.
    assign w_osync  = r_done_reg & proc_done & ~all_done;

    assign stuck    = proc_blk | w_osync;
    assign finished = r_done_reg & ~w_osync;
    assign done_reg = r_done_reg;

endmodule
`default_nettype wire

// File: rtl/dataflow_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_deadlock_monitor
// Purpose  : Deadlock / stall monitor for an HLS dataflow region. Reports a
//            deadlock once every unfinished process has been stuck for
//            'threshold' consecutive cycles and latches the origin process
//            and the stuck vector for debug readout.
// Ports    : dl_clock, dl_reset (sync, active-low)
//            proc_blk, proc_done, proc_continue [N_PROC] : process status
//            all_finish : region complete, suppresses detection
//            threshold  [CNT_W] : cycles required (0 behaves as 1)
//            clear      : pulse, drops detection and counter
//            dl_detect, dl_origin, dl_snapshot : detection and debug latches
//            stall_cnt  [CNT_W] : saturating consecutive-candidate count
//            done_reg   [N_PROC] : registered proc_done & ~proc_continue
// Revision : 1.0 - initial release
// ============================================================================
module dataflow_deadlock_monitor
    import dl_monitor_pkg::*;
#(
    parameter int N_PROC = 2,
    parameter int CNT_W  = 16,
    parameter int STICKY = 1
) (
    input  logic              dl_clock,
    input  logic              dl_reset,
    input  logic [N_PROC-1:0] proc_blk,
    input  logic [N_PROC-1:0] proc_done,
    input  logic [N_PROC-1:0] proc_continue,
    input  logic              all_finish,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              clear,
    output logic              dl_detect,
    output logic [N_PROC-1:0] dl_origin,
    output logic [N_PROC-1:0] dl_snapshot,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [N_PROC-1:0] done_reg
);

    logic [N_PROC-1:0]      w_done_reg;
    logic [N_PROC-1:0]      w_stuck;
    logic [N_PROC-1:0]      w_finished;
    logic                   w_all_done;
    logic                   w_candidate;
    logic [DL_MAX_PROC-1:0] w_stuck_pad;
    logic [DL_MAX_PROC-1:0] w_origin_full;
    logic [N_PROC-1:0]      w_origin;
    logic [CNT_W:0]         w_cnt_inc;
    logic [CNT_W:0]         w_thr_eff;
    logic                   w_hit;
    logic [CNT_W-1:0]       w_cnt_sat;

    dl_state_e              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_detect;
    logic [N_PROC-1:0]      r_origin;
    logic [N_PROC-1:0]      r_snapshot;

    assign w_all_done = &proc_done;

    generate
        for (genvar gi = 0; gi < N_PROC; gi++) begin : g_proc
            dl_proc_status u_status (
                .dl_clock      (dl_clock),
                .dl_reset      (dl_reset),
                .proc_blk      (proc_blk[gi]),
                .proc_done     (proc_done[gi]),
                .proc_continue (proc_continue[gi]),
                .all_done      (w_all_done),
                .done_reg      (w_done_reg[gi]),
                .stuck         (w_stuck[gi]),
                .finished      (w_finished[gi])
            );
        end
    endgenerate

    // Deadlock candidate: something is stuck and nothing is making progress.
    // all_finish is folded in here, so it drops IDLE/COUNT back to IDLE and
    // only a sticky detection survives it.
    assign w_candidate = ~all_finish & (|w_stuck) & (&(w_stuck | w_finished));

    always_comb begin
        w_stuck_pad               = '0;
        w_stuck_pad[N_PROC-1:0]   = w_stuck;
    end

    assign w_origin_full = lowest_onehot(w_stuck_pad);
    assign w_origin      = w_origin_full[N_PROC-1:0];

    // Bits above N_PROC are always zero because the input padding is zero.
    generate
        if (N_PROC < DL_MAX_PROC) begin : g_origin_hi
            logic w_origin_hi_unused;
            assign w_origin_hi_unused = |w_origin_full[DL_MAX_PROC-1:N_PROC];
        end
    endgenerate

    // Counter arithmetic is one bit wider so the compare against the
    // threshold stays correct at saturation.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_thr_eff = (threshold == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, threshold};
    assign w_hit     = (w_cnt_inc >= w_thr_eff);
    assign w_cnt_sat = w_cnt_inc[CNT_W] ? r_cnt : w_cnt_inc[CNT_W-1:0];

    always_ff @(posedge dl_clock) begin
        if (!dl_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_detect   <= 1'b0;
            r_origin   <= '0;
            r_snapshot <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_detect   <= 1'b0;
            r_origin   <= '0;
            r_snapshot <= '0;
        end else begin
            case (r_state)
                // IDLE counts its first candidate edge itself, so a threshold
                // of 1 detects on that very edge.
                IDLE, COUNT: begin
                    if (w_candidate) begin
                        r_cnt <= w_cnt_sat;
                        if (w_hit) begin
                            r_state    <= DETECTED;
                            r_detect   <= 1'b1;
                            r_origin   <= w_origin;
                            r_snapshot <= w_stuck;
                        end else begin
                            r_state    <= COUNT;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                DETECTED: begin
                    if (w_candidate) begin
                        r_cnt <= w_cnt_sat;
                    end else begin
                        r_cnt <= '0;
                        if (STICKY == 0) begin
                            r_state  <= IDLE;
                            r_detect <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_detect <= 1'b0;
                end
            endcase
        end
    end

    assign dl_detect   = r_detect;
    assign dl_origin   = r_origin;
    assign dl_snapshot = r_snapshot;
    assign stall_cnt   = r_cnt;
    assign done_reg    = w_done_reg;

endmodule
`default_nettype wire

// File: tb/tb_dataflow_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dataflow_deadlock_monitor
// Purpose  : Self-checking bench. Two monitor instances (4 processes sticky,
//            3 processes non-sticky with a 3-bit counter) are driven from a
//            directed vector table, hand-written corner sequences and random
//            stimulus, and compared against a behavioural model each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dataflow_deadlock_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_PROC=4, CNT_W=16, STICKY=1
    logic        a_rst_n, a_af, a_clr;
    logic [3:0]  a_blk, a_done, a_cont;
    logic [15:0] a_thr;
    logic        a_det;
    logic [3:0]  a_org, a_snap, a_dreg;
    logic [15:0] a_cnt;

    // Instance B: N_PROC=3, CNT_W=3, STICKY=0
    logic        b_rst_n, b_af, b_clr;
    logic [2:0]  b_blk, b_done, b_cont;
    logic [2:0]  b_thr;
    logic        b_det;
    logic [2:0]  b_org, b_snap, b_dreg;
    logic [2:0]  b_cnt;

    dataflow_deadlock_monitor #(.N_PROC(4), .CNT_W(16), .STICKY(1)) dut_a (
        .dl_clock(clk), .dl_reset(a_rst_n), .proc_blk(a_blk), .proc_done(a_done),
        .proc_continue(a_cont), .all_finish(a_af), .threshold(a_thr), .clear(a_clr),
        .dl_detect(a_det), .dl_origin(a_org), .dl_snapshot(a_snap),
        .stall_cnt(a_cnt), .done_reg(a_dreg)
    );

    dataflow_deadlock_monitor #(.N_PROC(3), .CNT_W(3), .STICKY(0)) dut_b (
        .dl_clock(clk), .dl_reset(b_rst_n), .proc_blk(b_blk), .proc_done(b_done),
        .proc_continue(b_cont), .all_finish(b_af), .threshold(b_thr), .clear(b_clr),
        .dl_detect(b_det), .dl_origin(b_org), .dl_snapshot(b_snap),
        .stall_cnt(b_cnt), .done_reg(b_dreg)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          det;
        logic [31:0] org;
        logic [31:0] snap;
        logic [31:0] dreg;
        int unsigned cnt;
    } mstate_t;

    mstate_t ma = '{default: '0};
    mstate_t mb = '{default: '0};

    function automatic mstate_t model_step(
        input mstate_t s, input int n, input bit sticky, input int unsigned cmax,
        input bit rst_n, input logic [31:0] blk, input logic [31:0] done,
        input logic [31:0] cont, input bit af, input int unsigned thr, input bit clr
    );
        mstate_t     r;
        logic [31:0] mask, osync, stuck, fin;
        bit          cand;
        int unsigned need;
        r     = s;
        mask  = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        osync = ((done & mask) == mask) ? 32'd0 : (s.dreg & done & mask);
        stuck = (blk | osync) & mask;
        fin   = s.dreg & ~osync & mask;
        cand  = !af && (stuck != 0) && ((stuck | fin) == mask);
        need  = (thr == 0) ? 1 : thr;
        r.dreg = done & ~cont & mask;
        if (!rst_n) begin
            r = '{default: '0};
        end else if (clr) begin
            r.det = 0; r.org = 0; r.snap = 0; r.cnt = 0;
        end else if (s.det && (sticky || cand)) begin
            r.cnt = cand ? ((s.cnt < cmax) ? s.cnt + 1 : cmax) : 0;
        end else if (cand) begin
            r.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
            r.det = (s.cnt + 1 >= need);
            if (r.det) begin
                r.snap = stuck;
                r.org  = 0;
                for (int i = 31; i >= 0; i--) if (stuck[i]) r.org = 32'd1 << i;
            end
        end else begin
            r.det = 0;
            r.cnt = 0;
        end
        return r;
    endfunction

    // One clock: predict from the current inputs, advance, compare both DUTs.
    task automatic step();
        mstate_t na, nb;
        na = model_step(ma, 4, 1'b1, 65535, a_rst_n, 32'(a_blk), 32'(a_done),
                        32'(a_cont), a_af, 32'(a_thr), a_clr);
        nb = model_step(mb, 3, 1'b0, 7, b_rst_n, 32'(b_blk), 32'(b_done),
                        32'(b_cont), b_af, 32'(b_thr), b_clr);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        chk("a_detect",   32'(a_det),  32'(ma.det));
        chk("a_origin",   32'(a_org),  ma.org);
        chk("a_snapshot", 32'(a_snap), ma.snap);
        chk("a_stallcnt", 32'(a_cnt),  ma.cnt);
        chk("a_donereg",  32'(a_dreg), ma.dreg);
        chk("b_detect",   32'(b_det),  32'(mb.det));
        chk("b_origin",   32'(b_org),  mb.org);
        chk("b_snapshot", 32'(b_snap), mb.snap);
        chk("b_stallcnt", 32'(b_cnt),  mb.cnt);
        chk("b_donereg",  32'(b_dreg), mb.dreg);
    endtask

    // ---------------- directed vector table for instance A ----------------
    typedef struct {
        bit          rst_n;
        logic [3:0]  blk, done, cont;
        bit          af;
        logic [15:0] thr;
        bit          clr;
        int          rep;
        bit          e_det;
        logic [3:0]  e_org, e_snap;
        logic [15:0] e_cnt;
        logic [3:0]  e_dreg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input bit rst_n, input logic [3:0] blk, input logic [3:0] done,
        input logic [3:0] cont, input bit af, input logic [15:0] thr, input bit clr,
        input int rep, input bit det, input logic [3:0] org, input logic [3:0] snap,
        input logic [15:0] cnt, input logic [3:0] dreg
    );
        vec_t v;
        v.rst_n = rst_n; v.blk = blk; v.done = done; v.cont = cont; v.af = af;
        v.thr = thr; v.clr = clr; v.rep = rep; v.e_det = det; v.e_org = org;
        v.e_snap = snap; v.e_cnt = cnt; v.e_dreg = dreg;
        tbl.push_back(v);
    endtask

    initial begin
        a_rst_n = 0; a_blk = 0; a_done = 0; a_cont = 0; a_af = 0; a_thr = 16'd4; a_clr = 0;
        b_rst_n = 0; b_blk = 0; b_done = 0; b_cont = 0; b_af = 0; b_thr = 3'd2; b_clr = 0;

        //   rst blk    done   cont   af thr     clr rep  det org    snap   cnt     dreg
        // reset with busy inputs
        add(0, 4'hF, 4'hF, 4'h0, 0, 16'd4, 0, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        // one blocked process, the rest finished (all done, not continued)
        add(1, 4'h2, 4'hF, 4'h0, 0, 16'd4, 0, 1,   0, 4'h0, 4'h0, 16'd0, 4'hF);
        add(1, 4'h2, 4'hF, 4'h0, 0, 16'd4, 0, 3,   0, 4'h0, 4'h0, 16'd3, 4'hF);
        add(1, 4'h2, 4'hF, 4'h0, 0, 16'd4, 0, 1,   1, 4'h2, 4'h2, 16'd4, 4'hF);
        // sticky detection survives all_finish and idle inputs, then clear
        add(1, 4'h2, 4'hF, 4'h0, 1, 16'd4, 0, 1,   1, 4'h2, 4'h2, 16'd0, 4'hF);
        add(1, 4'h0, 4'h0, 4'h0, 0, 16'd4, 0, 2,   1, 4'h2, 4'h2, 16'd0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 16'd4, 1, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        // all blocked 7 cycles, one drops, restart and detect after 8
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd8, 0, 7,   0, 4'h0, 4'h0, 16'd7, 4'h0);
        add(1, 4'hB, 4'h0, 4'h0, 0, 16'd8, 0, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd8, 0, 7,   0, 4'h0, 4'h0, 16'd7, 4'h0);
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd8, 0, 1,   1, 4'h1, 4'hF, 16'd8, 4'h0);
        // clear together with candidate, then counting restarts at 1
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd8, 1, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd8, 0, 1,   0, 4'h0, 4'h0, 16'd1, 4'h0);
        // reset in COUNT
        add(0, 4'hF, 4'h0, 4'h0, 0, 16'd8, 0, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd8, 0, 1,   0, 4'h0, 4'h0, 16'd1, 4'h0);
        // threshold lowered below the count detects at the next edge
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd1, 0, 1,   1, 4'h1, 4'hF, 16'd2, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 16'd1, 1, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        // threshold 0 behaves as 1
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd0, 0, 1,   1, 4'h1, 4'hF, 16'd1, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 16'd0, 1, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        // output-sync stall of process 0 completes the stuck vector a cycle late
        add(1, 4'hE, 4'h1, 4'h0, 0, 16'd3, 0, 1,   0, 4'h0, 4'h0, 16'd0, 4'h1);
        add(1, 4'hE, 4'h1, 4'h0, 0, 16'd3, 0, 3,   1, 4'h1, 4'hF, 16'd3, 4'h1);
        add(1, 4'hE, 4'h1, 4'h1, 0, 16'd3, 0, 1,   1, 4'h1, 4'hF, 16'd4, 4'h0);
        add(1, 4'hE, 4'h1, 4'h1, 0, 16'd3, 0, 1,   1, 4'h1, 4'hF, 16'd0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 16'd3, 1, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);
        // all_finish aborts counting
        add(1, 4'hF, 4'h0, 4'h0, 0, 16'd5, 0, 2,   0, 4'h0, 4'h0, 16'd2, 4'h0);
        add(1, 4'hF, 4'h0, 4'h0, 1, 16'd5, 0, 1,   0, 4'h0, 4'h0, 16'd0, 4'h0);

        foreach (tbl[i]) begin
            a_rst_n = tbl[i].rst_n; a_blk = tbl[i].blk; a_done = tbl[i].done;
            a_cont = tbl[i].cont; a_af = tbl[i].af; a_thr = tbl[i].thr; a_clr = tbl[i].clr;
            for (int r = 0; r < tbl[i].rep; r++) step();
            b_rst_n = 1;
            chk($sformatf("row%0d_det", i),  32'(a_det),  32'(tbl[i].e_det));
            chk($sformatf("row%0d_org", i),  32'(a_org),  32'(tbl[i].e_org));
            chk($sformatf("row%0d_snap", i), 32'(a_snap), 32'(tbl[i].e_snap));
            chk($sformatf("row%0d_cnt", i),  32'(a_cnt),  32'(tbl[i].e_cnt));
            chk($sformatf("row%0d_dreg", i), 32'(a_dreg), 32'(tbl[i].e_dreg));
        end
        a_blk = 0; a_done = 0; a_cont = 0; a_af = 0; a_clr = 0;

        // ---------------- hand sequences on non-sticky instance B ----------------
        b_blk = 3'b111; b_thr = 3'd2;
        step();
        chk("b_seq_cnt1", 32'(b_cnt), 32'd1);
        chk("b_seq_nodet", 32'(b_det), 32'd0);
        step();
        chk("b_seq_det", 32'(b_det), 32'd1);
        chk("b_seq_org", 32'(b_org), 32'h1);
        b_blk = 3'b000;
        step();
        chk("b_drop_det", 32'(b_det), 32'd0);
        chk("b_drop_cnt", 32'(b_cnt), 32'd0);
        // saturation of the 3-bit counter while detected
        b_blk = 3'b111; b_thr = 3'd7;
        repeat (9) step();
        chk("b_sat_det", 32'(b_det), 32'd1);
        chk("b_sat_cnt", 32'(b_cnt), 32'd7);
        // all_finish drops a non-sticky detection
        b_af = 1;
        step();
        chk("b_af_det", 32'(b_det), 32'd0);
        b_af = 0; b_blk = 0;
        step();

        // ---------------- randomized phase against the model ----------------
        for (int c = 0; c < 600; c++) begin
            a_rst_n = ($urandom_range(0, 63) != 0);
            a_blk   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            a_done  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            a_cont  = 4'($urandom);
            a_af    = ($urandom_range(0, 15) == 0);
            a_clr   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) a_thr = 16'($urandom_range(0, 6));
            b_rst_n = ($urandom_range(0, 63) != 0);
            b_blk   = ($urandom_range(0, 3) != 0) ? 3'h7 : 3'($urandom);
            b_done  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'h0;
            b_cont  = 3'($urandom);
            b_af    = ($urandom_range(0, 15) == 0);
            b_clr   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) b_thr = 3'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
